decode_stage: RTL

- Registered, parametrised instruction-decode pipeline stage between fetch and execute.
- Splits each instruction into opcode, register addresses, sign-extended immediate and control flags.
- Flags: write_reg, use_imm, write_mem, mem2reg, branch, illegal.
- Ready/valid handshake on both sides; 2-entry skid buffer for full throughput under back-pressure; synchronous flush for taken branches.

---
 rtl/decode_stage_pkg.sv | 51 +++++
 rtl/instr_field_decode.sv | 71 +++++++
 rtl/decode_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - opcode set, decoded bundle type and default widths for decode_stage
package header;

    localparam int DEF_XLEN    = 64;
    localparam int DEF_OP_W    = 6;
    localparam int DEF_RADDR_W = 5;

    // Bundle fields are sized for the widest supported configuration; narrower instances use the low bits.
    localparam int MAX_XLEN    = 64;
    localparam int MAX_OP_W    = 8;
    localparam int MAX_RADDR_W = 8;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_NOP  = 6'h00,
        OP_ADD  = 6'h01,
        OP_SUB  = 6'h02,
        OP_LDR  = 6'h08,
        OP_LDRI = 6'h09,
        OP_STR  = 6'h0A,
        OP_STRI = 6'h0B,
        OP_B    = 6'h10
    } opcode_e;

    typedef struct packed {
        logic [MAX_OP_W-1:0]    op;
        logic [MAX_RADDR_W-1:0] write_addr;
        logic [MAX_RADDR_W-1:0] addr_a;
        logic [MAX_RADDR_W-1:0] addr_b;
        logic [MAX_XLEN-1:0]    imm;
        logic                   write_reg;
        logic                   use_imm;
        logic                   write_mem;
        logic                   mem2reg;
        logic                   branch;
        logic                   illegal;
    } decode_bundle_t;

    function automatic logic is_legal_op(input logic [MAX_OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        if (op[MAX_OP_W-1:DEF_OP_W] == '0) begin
            case (op[DEF_OP_W-1:0])
                OP_NOP, OP_ADD, OP_SUB, OP_LDR, OP_LDRI,
                OP_STR, OP_STRI, OP_B:  legal = 1'b1;
                default:                legal = 1'b0;
            endcase
        end
        return legal;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational split of one instruction into a decoded bundle
module instr_field_decode
    import header::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int OP_W    = DEF_OP_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int IMM_W   = XLEN / 2
) (
    input  logic [XLEN-1:0] instr_i,
    output decode_bundle_t  bundle_o
);

    // Field numbering counts from the MSB: field bit 0 is instr_i[XLEN-1].
    localparam int WA_HI = XLEN - 1 - OP_W;
    localparam int A_HI  = WA_HI - RADDR_W;
    localparam int B_HI  = A_HI - RADDR_W;

    logic [OP_W-1:0]    op_raw;
    logic [RADDR_W-1:0] wa_raw;
    logic [RADDR_W-1:0] a_raw;
    logic [RADDR_W-1:0] b_raw;
    logic [IMM_W-1:0]   imm_raw;
    logic               unused_instr;
    decode_bundle_t     b;

    assign op_raw       = instr_i[XLEN-1 -: OP_W];
    assign wa_raw       = instr_i[WA_HI -: RADDR_W];
    assign a_raw        = instr_i[A_HI -: RADDR_W];
    assign b_raw        = instr_i[B_HI -: RADDR_W];
    assign imm_raw      = instr_i[IMM_W-1:0];
    assign unused_instr = ^instr_i;

    always_comb begin
        b            = '0;
        b.op         = MAX_OP_W'(op_raw);
        b.write_addr = MAX_RADDR_W'(wa_raw);
        b.addr_a     = MAX_RADDR_W'(a_raw);
        b.addr_b     = MAX_RADDR_W'(b_raw);
        b.imm        = {{(MAX_XLEN-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
        b.write_reg  = 1'b1;
        if (!is_legal_op(b.op)) begin
            b.illegal   = 1'b1;
            b.write_reg = 1'b0;
        end else begin
            case (b.op[DEF_OP_W-1:0])
                OP_LDR:  b.mem2reg = 1'b1;
                OP_LDRI: begin
                    b.mem2reg = 1'b1;
                    b.use_imm = 1'b1;
                end
                OP_STR:  begin
                    b.write_mem = 1'b1;
                    b.write_reg = 1'b0;
                end
                OP_STRI: begin
                    b.write_mem = 1'b1;
                    b.write_reg = 1'b0;
                    b.use_imm   = 1'b1;
                end
                OP_B:    begin
                    b.branch    = 1'b1;
                    b.write_reg = 1'b0;
                end
                default: ;
            endcase
        end
        bundle_o = b;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with output and skid registers and flush
module decode_stage
    import header::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int OP_W    = DEF_OP_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int IMM_W   = XLEN / 2
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    out_op,
    output logic [RADDR_W-1:0] out_write_addr,
    output logic [RADDR_W-1:0] out_addr_a,
    output logic [RADDR_W-1:0] out_addr_b,
    output logic [XLEN-1:0]    out_imm,
    output logic               out_write_reg,
    output logic               out_use_imm,
    output logic               out_write_mem,
    output logic               out_mem2reg,
    output logic               out_branch,
    output logic               out_illegal
);

    // ONE means OUT holds a bundle; FULL means OUT and SKID both hold one.
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} occ_e;

    occ_e           state_q, state_d;
    decode_bundle_t dec_bundle;
    decode_bundle_t out_q, out_d;
    decode_bundle_t skid_q, skid_d;
    logic           accept;
    logic           drain;
    logic           unused_bits;

    instr_field_decode #(
        .XLEN    (XLEN),
        .OP_W    (OP_W),
        .RADDR_W (RADDR_W),
        .IMM_W   (IMM_W)
    ) u_field_decode (
        .instr_i  (in_instr),
        .bundle_o (dec_bundle)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);
    assign accept    = in_valid && in_ready && !flush;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    out_d   = dec_bundle;
                    state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_d = dec_bundle;
                    end else if (accept) begin
                        skid_d  = dec_bundle;
                        state_d = ST_FULL;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: if (drain) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign out_op         = out_q.op[OP_W-1:0];
    assign out_write_addr = out_q.write_addr[RADDR_W-1:0];
    assign out_addr_a     = out_q.addr_a[RADDR_W-1:0];
    assign out_addr_b     = out_q.addr_b[RADDR_W-1:0];
    assign out_imm        = out_q.imm[XLEN-1:0];
    assign out_write_reg  = out_q.write_reg;
    assign out_use_imm    = out_q.use_imm;
    assign out_write_mem  = out_q.write_mem;
    assign out_mem2reg    = out_q.mem2reg;
    assign out_branch     = out_q.branch;
    assign out_illegal    = out_q.illegal;
    assign unused_bits    = ^out_q;

endmodule
